// File: rtl/mod20_share_arb_if.sv
//------------------------------------------------------------------------------
// Module      : mod20_share_arb_if
// Description : Requester/result bundle for the shared mod-20 offset unit.
//               The master side belongs to the producers; the slave side
//               belongs to the arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mod20_share_arb_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] opnd;
  logic [5*NREQ-1:0] offs;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [4:0]        res;

  modport master (
    output req, opnd, offs,
    input  gnt, busy, res_valid, res_id, res
  );

  modport slave (
    input  req, opnd, offs,
    output gnt, busy, res_valid, res_id, res
  );
endinterface

`default_nettype wire

// File: rtl/mod20_share_arb.sv
//------------------------------------------------------------------------------
// Module      : mod20_share_arb
// Description : Round-robin arbiter in front of one iterative unit that
//               computes ((a mod MODULUS) + b) mod MODULUS by repeated
//               subtraction. One job in flight; results tagged with the
//               requester index.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod20_share_arb #(
  parameter int NREQ    = 4,
  parameter int MODULUS = 20
) (
  input  wire logic        clk,
  input  wire logic        rst,   // asynchronous, active low
  mod20_share_arb_if.slave bus
);

  localparam int             IDW    = $clog2(NREQ);
  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [6:0]     MOD_W  = 7'(MODULUS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RED1 = 3'd1,
    ADD  = 3'd2,
    RED2 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      acc_q, acc_d;
  logic [4:0]      off_q, off_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [4:0]      res_q, res_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_valid_q, res_valid_d;

  logic [NREQ-1:0] gnt_raw;
  logic            found;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  sel_next;
  logic [IDW:0]    scan;
  logic [IDW:0]    sel_inc;

  logic [6:0]      opnd_arr [NREQ];
  logic [4:0]      offs_arr [NREQ];

  // Unpack the flat operand buses into per-requester views.
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign opnd_arr[g] = bus.opnd[7*g +: 7];
      assign offs_arr[g] = bus.offs[5*g +: 5];
    end
  endgenerate

  // Pick the first requester at or after ptr, wrapping, and the pointer after it.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan     = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= NREQ_W) begin
        scan = scan - NREQ_W;
      end
      if (!found && bus.req[scan[IDW-1:0]]) begin
        found = 1'b1;
        sel   = scan[IDW-1:0];
      end
    end
    sel_inc  = {1'b0, sel} + {{IDW{1'b0}}, 1'b1};
    sel_next = (sel_inc == NREQ_W) ? '0 : sel_inc[IDW-1:0];
  end

  // Next-state and datapath: grant in IDLE, reduce, add offset, reduce, publish.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    off_d       = off_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    gnt_raw     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_raw[sel] = 1'b1;
          acc_d        = opnd_arr[sel];
          off_d        = offs_arr[sel];
          id_d         = sel;
          ptr_d        = sel_next;
          state_d      = RED1;
        end
      end
      RED1: begin
        if (acc_q >= MOD_W) begin
          acc_d = acc_q - MOD_W;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        // acc < MODULUS here, so bit 6 is already zero; the sum fits 7 bits.
        acc_d   = {1'b0, acc_q[5:0]} + {2'b00, off_q};
        state_d = RED2;
      end
      RED2: begin
        if (acc_q >= MOD_W) begin
          acc_d = acc_q - MOD_W;
        end else begin
          // Load the result registers on the way into DONE so they are
          // valid during the DONE cycle itself.
          res_d       = acc_q[4:0];
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      off_q       <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      off_q       <= off_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Grant is combinational from IDLE but must stay low while reset is held.
  assign bus.gnt       = rst ? gnt_raw : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res       = res_q;

endmodule

`default_nettype wire
